// File: rtl/rr_arb4_32bit_if.sv
// rr_arb4_32bit_if: request/ack fan-in and valid/ready result bus of the round-robin arbiter
interface rr_arb4_32bit_if #(parameter int WIDTH = 32);
  logic [3:0]       i_req;
  logic [WIDTH-1:0] i_data0;
  logic [WIDTH-1:0] i_data1;
  logic [WIDTH-1:0] i_data2;
  logic [WIDTH-1:0] i_data3;
  logic [3:0]       o_ack;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [1:0]       o_sel;
  logic             i_ready;
  modport slave (
    input  i_req, i_data0, i_data1, i_data2, i_data3, i_ready,
    output o_ack, o_valid, o_data, o_sel
  );
  modport master (
    output i_req, i_data0, i_data1, i_data2, i_data3, i_ready,
    input  o_ack, o_valid, o_data, o_sel
  );
endinterface

// File: rtl/rr_arb4_32bit.sv
// rr_arb4_32bit: four-way round-robin arbiter feeding one registered valid/ready output stage
module rr_arb4_32bit #(parameter int WIDTH = 32) (
  input logic            i_clk,
  input logic            i_reset,
  rr_arb4_32bit_if.slave bus
);
  logic [1:0]       ptr;
  logic [1:0]       g;
  logic [1:0]       idx;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] mux;
  // first requester at or after ptr, wrapping modulo 4
  always_comb begin
    found = 1'b0;
    g = ptr;
    idx = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign load_en = !bus.o_valid || bus.i_ready;
  assign xfer = load_en && found && !i_reset;
  assign bus.o_ack = xfer ? 4'b0001 << g : 4'b0000;
  assign mux = g == 2'd0 ? bus.i_data0 :
               g == 2'd1 ? bus.i_data1 :
               g == 2'd2 ? bus.i_data2 : bus.i_data3;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_valid <= 1'b0;
      bus.o_data <= '0;
      bus.o_sel <= 2'd0;
      ptr <= 2'd0;
    end else if (xfer) begin
      bus.o_valid <= 1'b1;
      bus.o_data <= mux;
      bus.o_sel <= g;
      ptr <= g + 2'd1;
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end
endmodule
